// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing one register-file write port between two writeback requesters,
// with 1-entry holding registers, RAW hazard flags and a saturating contention counter.
module regfile_wr_arbiter #(
  parameter int unsigned BITSIZE = 16,
  parameter int unsigned ADDSIZE = 4,
  parameter int unsigned CNTSIZE = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               v0,
  input  logic [ADDSIZE-1:0] a0,
  input  logic [BITSIZE-1:0] d0,
  output logic               rdy0,
  input  logic               v1,
  input  logic [ADDSIZE-1:0] a1,
  input  logic [BITSIZE-1:0] d1,
  output logic               rdy1,
  output logic [ADDSIZE-1:0] rw,
  output logic [BITSIZE-1:0] wdat,
  output logic               wren,
  input  logic [ADDSIZE-1:0] ra,
  input  logic [ADDSIZE-1:0] rb,
  output logic               haz_a,
  output logic               haz_b,
  output logic [CNTSIZE-1:0] cont_cnt
);

  logic               full0, full1;
  logic [ADDSIZE-1:0] hold0_addr, hold1_addr;
  logic [BITSIZE-1:0] hold0_data, hold1_data;
  logic               rr_last;
  logic               gnt0, gnt1;
  logic               acc0, acc1;

  // Under contention the port not granted last time wins.
  always_comb begin
    gnt0 = full0 & (~full1 | rr_last);
    gnt1 = full1 & (~full0 | ~rr_last);
  end

  // A port whose entry drains this cycle can refill in the same cycle.
  assign rdy0 = ~full0 | gnt0;
  assign rdy1 = ~full1 | gnt1;
  assign acc0 = v0 & rdy0;
  assign acc1 = v1 & rdy1;

  always_comb begin
    haz_a = (full0 & (hold0_addr == ra)) | (full1 & (hold1_addr == ra)) | (wren & (rw == ra));
    haz_b = (full0 & (hold0_addr == rb)) | (full1 & (hold1_addr == rb)) | (wren & (rw == rb));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full0      <= 1'b0;
      full1      <= 1'b0;
      hold0_addr <= '0;
      hold0_data <= '0;
      hold1_addr <= '0;
      hold1_data <= '0;
      rr_last    <= 1'b1;
    end else begin
      if (acc0) begin
        hold0_addr <= a0;
        hold0_data <= d0;
        full0      <= 1'b1;
      end else if (gnt0) begin
        full0 <= 1'b0;
      end
      if (acc1) begin
        hold1_addr <= a1;
        hold1_data <= d1;
        full1      <= 1'b1;
      end else if (gnt1) begin
        full1 <= 1'b0;
      end
      if (gnt1) begin
        rr_last <= 1'b1;
      end else if (gnt0) begin
        rr_last <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wren <= 1'b0;
      rw   <= '0;
      wdat <= '0;
    end else begin
      wren <= gnt0 | gnt1;
      if (gnt0) begin
        rw   <= hold0_addr;
        wdat <= hold0_data;
      end else if (gnt1) begin
        rw   <= hold1_addr;
        wdat <= hold1_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cont_cnt <= '0;
    end else if (full0 && full1 && (cont_cnt != {CNTSIZE{1'b1}})) begin
      cont_cnt <= cont_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: a default instance plus a 3-bit-counter instance
// that shares the same stimulus for the saturation case.
module tb_regfile_wr_arbiter;

  logic        clk, rst;
  logic        v0, v1;
  logic [3:0]  a0, a1, ra, rb;
  logic [15:0] d0, d1;
  logic        rdy0, rdy1, wren, haz_a, haz_b;
  logic [3:0]  rw;
  logic [15:0] wdat, cont_cnt;

  logic        s_rdy0, s_rdy1, s_wren, s_haz_a, s_haz_b;
  logic [3:0]  s_rw;
  logic [15:0] s_wdat;
  logic [2:0]  s_cnt;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  logic [15:0] rf [16];
  logic [3:0]  wlog [$];

  regfile_wr_arbiter dut (
    .clk(clk), .rst(rst),
    .v0(v0), .a0(a0), .d0(d0), .rdy0(rdy0),
    .v1(v1), .a1(a1), .d1(d1), .rdy1(rdy1),
    .rw(rw), .wdat(wdat), .wren(wren),
    .ra(ra), .rb(rb), .haz_a(haz_a), .haz_b(haz_b),
    .cont_cnt(cont_cnt)
  );

  regfile_wr_arbiter #(.BITSIZE(16), .ADDSIZE(4), .CNTSIZE(3)) dut_sat (
    .clk(clk), .rst(rst),
    .v0(v0), .a0(a0), .d0(d0), .rdy0(s_rdy0),
    .v1(v1), .a1(a1), .d1(d1), .rdy1(s_rdy1),
    .rw(s_rw), .wdat(s_wdat), .wren(s_wren),
    .ra(ra), .rb(rb), .haz_a(s_haz_a), .haz_b(s_haz_b),
    .cont_cnt(s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file model: commits on the edge where wren is seen.
  always @(posedge clk) begin
    if (!rst && wren) begin
      rf[rw] = wdat;
      wlog.push_back(rw);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n0, n1;
    logic acc0, acc1;

    rst = 1'b1;
    v0 = 1'b0; v1 = 1'b0; a0 = '0; a1 = '0; d0 = '0; d1 = '0; ra = '0; rb = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_rdy0", 32'(rdy0), 32'd1);
    check("rst_rdy1", 32'(rdy1), 32'd1);
    check("rst_wren", 32'(wren), 32'd0);
    check("rst_cnt", 32'(cont_cnt), 32'd0);
    check("rst_rw", 32'(rw), 32'd0);
    check("rst_wdat", 32'(wdat), 32'd0);

    // Lone requester 0 streaming four writes
    for (int i = 0; i < 4; i++) begin
      v0 = 1'b1; a0 = 4'(3 + i); d0 = 16'hA003 + 16'(i);
      @(negedge clk);
      check("lone_rdy0", 32'(rdy0), 32'd1);
      if (i == 0) begin
        check("lone_wren0", 32'(wren), 32'd0);
      end else begin
        check("lone_wren", 32'(wren), 32'd1);
        check("lone_rw", 32'(rw), 32'(2 + i));
      end
    end
    v0 = 1'b0;
    @(negedge clk);
    check("lone_wren_last", 32'(wren), 32'd1);
    check("lone_rw_last", 32'(rw), 32'd6);
    check("lone_wdat_last", 32'(wdat), 32'hA006);
    @(negedge clk);
    check("lone_wren_off", 32'(wren), 32'd0);

    // Reset asserted mid-burst takes effect without a clock edge
    ra = 4'd7;
    v0 = 1'b1; a0 = 4'd7; d0 = 16'h7777;
    v1 = 1'b1; a1 = 4'd8; d1 = 16'h8888;
    @(negedge clk);
    @(negedge clk);
    check("burst_rdy1", 32'(rdy1), 32'd0);
    check("burst_wren", 32'(wren), 32'd1);
    check("burst_haz_a", 32'(haz_a), 32'd1);
    rst = 1'b1;
    #1;
    check("async_wren", 32'(wren), 32'd0);
    check("async_rdy1", 32'(rdy1), 32'd1);
    check("async_haz_a", 32'(haz_a), 32'd0);
    check("async_rw", 32'(rw), 32'd0);
    v0 = 1'b0; v1 = 1'b0;
    @(negedge clk);
    rst = 1'b0; ra = 4'd0;

    // Simultaneous same-address requests: port 0 first, port 1 wins the register
    v0 = 1'b1; a0 = 4'd2; d0 = 16'h1111;
    v1 = 1'b1; a1 = 4'd2; d1 = 16'h2222;
    @(negedge clk);
    v0 = 1'b0; v1 = 1'b0;
    check("tie_cnt0", 32'(cont_cnt), 32'd0);
    @(negedge clk);
    check("tie_wren", 32'(wren), 32'd1);
    check("tie_rw", 32'(rw), 32'd2);
    check("tie_first", 32'(wdat), 32'h1111);
    check("tie_cnt1", 32'(cont_cnt), 32'd1);
    @(negedge clk);
    check("tie_second", 32'(wdat), 32'h2222);
    check("tie_cnt_hold", 32'(cont_cnt), 32'd1);
    @(negedge clk);
    check("tie_rf2", 32'(rf[2]), 32'h2222);
    wlog.delete();

    // Both ports streaming six requests each
    n0 = 0; n1 = 0;
    for (int c = 0; c < 40 && (n0 < 6 || n1 < 6); c++) begin
      v0 = (n0 < 6); a0 = 4'(n0);     d0 = 16'hB000 + 16'(n0);
      v1 = (n1 < 6); a1 = 4'(8 + n1); d1 = 16'hC000 + 16'(n1);
      #1;
      if (c >= 1 && c <= 10) begin
        check("stream_rdy0", 32'(rdy0), 32'(c % 2));
        check("stream_rdy1", 32'(rdy1), 32'(1 - (c % 2)));
      end
      acc0 = v0 & rdy0;
      acc1 = v1 & rdy1;
      @(negedge clk);
      n0 += int'(acc0);
      n1 += int'(acc1);
    end
    v0 = 1'b0; v1 = 1'b0;
    check("stream_n0", 32'(n0), 32'd6);
    check("stream_n1", 32'(n1), 32'd6);
    repeat (4) @(negedge clk);
    check("stream_writes", 32'(wlog.size()), 32'd12);
    for (int k = 0; k < 12 && k < wlog.size(); k++) begin
      check("stream_order", 32'(wlog[k]), (k % 2 == 0) ? 32'(k / 2) : 32'(8 + k / 2));
    end
    for (int k = 0; k < 6; k++) begin
      check("stream_rf0", 32'(rf[k]), 32'hB000 + 32'(k));
      check("stream_rf1", 32'(rf[8 + k]), 32'hC000 + 32'(k));
    end
    check("stream_cnt", 32'(cont_cnt), 32'd12);

    // Hazard tracking through holding register and output stage
    ra = 4'd5; rb = 4'd6;
    v0 = 1'b1; a0 = 4'd5; d0 = 16'hD005;
    #1;
    check("haz_idle", 32'(haz_a), 32'd0);
    @(negedge clk);
    v0 = 1'b0;
    check("haz_hold_a", 32'(haz_a), 32'd1);
    check("haz_hold_b", 32'(haz_b), 32'd0);
    @(negedge clk);
    check("haz_out_a", 32'(haz_a), 32'd1);
    check("haz_out_b", 32'(haz_b), 32'd0);
    check("haz_out_rw", 32'(rw), 32'd5);
    @(negedge clk);
    check("haz_clear", 32'(haz_a), 32'd0);

    // Sustained contention saturates the 3-bit counter
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j <= 10; j++) begin
      v0 = 1'b1; a0 = 4'd1; d0 = 16'h0100 + 16'(j);
      v1 = 1'b1; a1 = 4'd2; d1 = 16'h0200 + 16'(j);
      @(negedge clk);
      if (j == 6) check("sat_cnt6", 32'(s_cnt), 32'd6);
      if (j == 7) check("sat_cnt7", 32'(s_cnt), 32'd7);
      if (j == 10) begin
        check("sat_stick", 32'(s_cnt), 32'd7);
        check("sat_wide", 32'(cont_cnt), 32'd10);
      end
    end
    v0 = 1'b0; v1 = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
